seq_mult_ctrl: RTL



---
 rtl/seq_mult_ctrl_if.sv | 29 ++
 rtl/seq_mult_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : seq_mult_ctrl_if                                     |
// | Purpose  : operand/result handshake bundle for seq_mult_ctrl    |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 result_valid;
  logic                 result_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output start_valid, a, b, result_ready,
    input  start_ready, result_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, result_ready,
    output start_ready, result_valid, product, busy
  );
endinterface
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : seq_mult_ctrl                                        |
// | Purpose  : shift-add unsigned multiplier, one adder, WIDTH cycles|
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  seq_mult_ctrl_if.slave     bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   prod_reg;
  logic                 valid_reg;
  logic                 busy_reg;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;

  assign addend  = acc_lo[0] ? mcand : '0;
  // Carry-out becomes the new MSB as the WIDTH+1-bit sum shifts right.
  assign shifted = {cout, sum, acc_lo[WIDTH-1:1]};

  RippleCarryAdder #(.WIDTH(WIDTH)) u_adder (
    .x    (acc_hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      prod_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            mcand    <= bus.a;
            acc_hi   <= '0;
            acc_lo   <= bus.b;
            cnt      <= '0;
            busy_reg <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= shifted;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST) begin
            prod_reg  <= shifted;
            valid_reg <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // A start request seen here waits for IDLE on the next edge.
          if (bus.result_ready) begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready  = (state == IDLE);
  assign bus.result_valid = valid_reg;
  assign bus.product      = prod_reg;
  assign bus.busy         = busy_reg;
endmodule

// +-----------------------------------------------------------------+
// | Module   : RippleCarryAdder                                     |
// | Purpose  : WIDTH-bit combinational ripple-carry adder           |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module RippleCarryAdder #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] x,
  input  wire logic [WIDTH-1:0] y,
  input  wire logic             cin,
  output logic [WIDTH-1:0]      sum,
  output logic                  cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[WIDTH];
endmodule
`default_nettype wire
